// File: rtl/prog_sequencer.sv
// -----------------------------------------------------------------------------
// prog_sequencer
//   Host-side program launcher for a small core. On a host request it pulses
//   core_start with the selected program index, counts RUN cycles until the
//   core reports halt, then holds ack until the host withdraws req. The
//   program index advances round-robin after every completed handshake.
//
// Optional feature (compile-time macro PROG_SEQUENCER_WATCHDOG_EN):
//   RUN is also ended once cycle_ct reaches TIMEOUT without core_done, and
//   timeout is set. With the macro undefined, timeout is tied low and no
//   watchdog logic exists.
//
// Parameters
//   NUM_PROGS  programs held in instruction ROM (1..4)
//   CNT_W      cycle counter width
//   TIMEOUT    watchdog limit in RUN cycles (1..2^CNT_W-1)
//
// Ports
//   clk         in   single clock, posedge
//   init_n      in   asynchronous active-low reset
//   req         in   host request, level, held until ack
//   ack         out  high from DONE entry until req drops
//   core_start  out  one-cycle start pulse to the core
//   prog_sel    out  program index to the core
//   core_done   in   core halt flag, sampled only in RUN
//   busy        out  high in LAUNCH and RUN
//   cycle_ct    out  RUN-cycle count of the current/last program
//   timeout     out  last program ended by the watchdog
// -----------------------------------------------------------------------------
module prog_sequencer #(
    parameter int unsigned NUM_PROGS = 3,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic             clk,
    input  logic             init_n,
    input  logic             req,
    output logic             ack,
    output logic             core_start,
    output logic [1:0]       prog_sel,
    input  logic             core_done,
    output logic             busy,
    output logic [CNT_W-1:0] cycle_ct,
    output logic             timeout
);

    // Elaboration-time parameter range checks.
    if (NUM_PROGS < 1 || NUM_PROGS > 4) begin : g_bad_num_progs
        $error("prog_sequencer: NUM_PROGS out of range 1..4");
    end
    if (TIMEOUT < 1 || TIMEOUT > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_timeout
        $error("prog_sequencer: TIMEOUT out of range 1..2^CNT_W-1");
    end

    localparam logic [1:0] LP_LAST_PROG = 2'(NUM_PROGS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_RUN    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           r_state;
    logic [1:0]       r_sync;
    logic             r_ack;
    logic             r_core_start;
    logic             r_busy;
    logic [1:0]       r_prog_sel;
    logic [CNT_W-1:0] r_cycle_ct;
    logic [CNT_W-1:0] w_ct_next;
    logic             w_run_ok;

    // Reset release synchroniser: asserts with init_n, releases after two edges.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[0], 1'b1};
        end
    end

    assign w_run_ok  = r_sync[1];
    // Saturating increment: hold at all-ones instead of wrapping.
    assign w_ct_next = (&r_cycle_ct) ? r_cycle_ct : r_cycle_ct + CNT_W'(1);

`ifdef PROG_SEQUENCER_WATCHDOG_EN
    localparam logic [CNT_W-1:0] LP_LIMIT = CNT_W'(TIMEOUT);
    logic r_timeout;
    logic w_wd_hit;
    // Limit is judged on the value this RUN cycle counts up to, so DONE is
    // entered holding exactly TIMEOUT.
    assign w_wd_hit = (w_ct_next == LP_LIMIT);
    assign timeout  = r_timeout;
`else
    assign timeout  = 1'b0;
`endif

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            r_state      <= S_IDLE;
            r_ack        <= 1'b0;
            r_core_start <= 1'b0;
            r_busy       <= 1'b0;
            r_prog_sel   <= '0;
            r_cycle_ct   <= '0;
`ifdef PROG_SEQUENCER_WATCHDOG_EN
            r_timeout    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req && w_run_ok) begin
                        r_state      <= S_LAUNCH;
                        r_core_start <= 1'b1;
                        r_busy       <= 1'b1;
                        r_cycle_ct   <= '0;
`ifdef PROG_SEQUENCER_WATCHDOG_EN
                        r_timeout    <= 1'b0;
`endif
                    end
                end
                S_LAUNCH: begin
                    r_state      <= S_RUN;
                    r_core_start <= 1'b0;
                end
                S_RUN: begin
                    r_cycle_ct <= w_ct_next;
                    // core_done takes priority over a coincident watchdog hit.
                    if (core_done) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_ack   <= 1'b1;
                    end
`ifdef PROG_SEQUENCER_WATCHDOG_EN
                    else if (w_wd_hit) begin
                        r_state   <= S_DONE;
                        r_busy    <= 1'b0;
                        r_ack     <= 1'b1;
                        r_timeout <= 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    if (!req) begin
                        r_state    <= S_IDLE;
                        r_ack      <= 1'b0;
                        r_prog_sel <= (r_prog_sel == LP_LAST_PROG) ? '0
                                                                   : r_prog_sel + 2'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ack        = r_ack;
    assign core_start = r_core_start;
    assign busy       = r_busy;
    assign prog_sel   = r_prog_sel;
    assign cycle_ct   = r_cycle_ct;

endmodule
